qm_refill_arbiter: RTL and testbench

- Arbitrates instruction-cache and data-cache line-refill requests onto the single external memory read port.
- Each grant runs a burst of LINE_WORDS single-word reads and streams the words back to the winning cache.
- Sits between qm_icache / qm_dcache miss logic and the memory bus interface in qm_top.
- Round-robin between the two caches so fetch and data misses cannot starve each other.

---
 rtl/qm_refill_arbiter.sv | 121 ++++++++++++
 tb/tb_qm_refill_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/qm_refill_arbiter.sv
// qm_refill_arbiter: round-robin icache/dcache line-refill arbiter onto one memory read port.
// Ports: clk, reset (async, active-high); ic_*/dc_* request address in, word/index/valid/done out;
// mem_req/mem_addr out, mem_ack/mem_rdata in.
// Optional build macro QM_REFILL_CWF_EN: critical-word-first burst start.
module qm_refill_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_req,
  input  logic [31:0]      ic_addr,
  output logic             ic_wvalid,
  output logic [IDX_W-1:0] ic_widx,
  output logic [31:0]      ic_wdata,
  output logic             ic_done,
  input  logic             dc_req,
  input  logic [31:0]      dc_addr,
  output logic             dc_wvalid,
  output logic [IDX_W-1:0] dc_widx,
  output logic [31:0]      dc_wdata,
  output logic             dc_done,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [29-IDX_W:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d, cnt_q, cnt_d, widx_q, widx_d, start_idx;
  logic              req_q, req_d, wvalid_q, wvalid_d, done_q, done_d;
  logic [31:0]       wdata_q, wdata_d, win_addr;
  logic              pick_dc, ack, unused_ok;
  // gnt/last: 1 = dcache. On a tie the requester that did not win last time is picked.
  assign pick_dc  = dc_req && (!ic_req || !last_q);
  assign win_addr = pick_dc ? dc_addr : ic_addr;
  assign ack      = req_q && mem_ack;
`ifdef QM_REFILL_CWF_EN
  assign start_idx = win_addr[IDX_W+1:2];
`else
  assign start_idx = '0;
`endif
  assign unused_ok = ^win_addr[IDX_W+1:0];
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    base_d   = base_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    wvalid_d = 1'b0;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (ic_req || dc_req) begin
        state_d = BURST;
        gnt_d   = pick_dc;
        last_d  = pick_dc;
        base_d  = win_addr[31:IDX_W+2];
        idx_d   = start_idx;
        cnt_d   = '0;
        req_d   = 1'b1;
      end
    end else if (ack) begin
      wdata_d  = mem_rdata;
      widx_d   = idx_q;
      wvalid_d = 1'b1;
      idx_d    = idx_q + 1'b1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(LINE_WORDS - 1)) begin
        done_d  = 1'b1;
        req_d   = 1'b0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      base_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      done_q   <= done_d;
    end
  end
  // gnt_q only changes at the end of an IDLE cycle, so it still names the
  // owner of the final word pulse that lands in that IDLE cycle.
  assign ic_wvalid = wvalid_q && !gnt_q;
  assign dc_wvalid = wvalid_q && gnt_q;
  assign ic_widx   = ic_wvalid ? widx_q : '0;
  assign dc_widx   = dc_wvalid ? widx_q : '0;
  assign ic_wdata  = ic_wvalid ? wdata_q : '0;
  assign dc_wdata  = dc_wvalid ? wdata_q : '0;
  assign ic_done   = done_q && !gnt_q;
  assign dc_done   = done_q && gnt_q;
  assign mem_req   = req_q;
  assign mem_addr  = {base_q, idx_q, 2'b00};
endmodule

// File: tb/tb_qm_refill_arbiter.sv
// tb_qm_refill_arbiter: scoreboard bench for qm_refill_arbiter.
module tb_qm_refill_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ic_req = 1'b0, dc_req = 1'b0, mem_ack = 1'b1;
  logic [31:0] ic_addr = '0, dc_addr = '0, mem_rdata, mem_addr;
  logic        ic_wvalid, ic_done, dc_wvalid, dc_done, mem_req;
  logic [1:0]  ic_widx, dc_widx;
  logic [31:0] ic_wdata, dc_wdata;
  bit          ack_mode = 1'b0;
  int          cyc = 0, checks = 0, errors = 0, acks_seen = 0, last_done_cyc = 0;
  logic [31:0] exp_addr[$];
  logic [71:0] exp_word[$];
`ifdef QM_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  qm_refill_arbiter #(.LINE_WORDS(4), .IDX_W(2)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_wvalid(ic_wvalid), .ic_widx(ic_widx),
    .ic_wdata(ic_wdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_wvalid(dc_wvalid), .dc_widx(dc_widx),
    .dc_wdata(dc_wdata), .dc_done(dc_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1 mem_ack = ack_mode ? (cyc % 3 == 0) : 1'b1;
  end

  function automatic logic [31:0] md(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction
  assign mem_rdata = md(mem_addr);

  function automatic logic [71:0] mk(bit dc, logic [1:0] ix, logic [31:0] d, bit done);
    return dc ? {36'b0, 1'b1, ix, d, done} : {1'b1, ix, d, done, 36'b0};
  endfunction

  always @(negedge clk) begin
    logic [71:0] got, want;
    logic [31:0] ea;
    if (!reset) begin
      if (mem_req && mem_ack) begin
        acks_seen++;
        ea = exp_addr.size() != 0 ? exp_addr.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (mem_addr !== ea) begin
          errors++;
          $display("FAIL mem_addr @%0d: got %h expected %h", cyc, mem_addr, ea);
        end
      end
      got  = {ic_wvalid, ic_widx, ic_wdata, ic_done, dc_wvalid, dc_widx, dc_wdata, dc_done};
      want = '0;
      if ((ic_wvalid || dc_wvalid) && exp_word.size() != 0) want = exp_word.pop_front();
      else if (ic_wvalid || dc_wvalid) want = {72{1'b1}};
      if (ic_done || dc_done) last_done_cyc = cyc;
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL word @%0d: got %h expected %h", cyc, got, want);
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push_burst(bit dc, logic [31:0] a);
    logic [1:0]  s;
    logic [1:0]  ix;
    logic [31:0] w;
    s = CWF ? a[3:2] : 2'd0;
    for (int i = 0; i < 4; i++) begin
      ix = s + 2'(i);
      w  = {a[31:4], ix, 2'b00};
      exp_addr.push_back(w);
      exp_word.push_back(mk(dc, ix, md(w), i == 3));
    end
  endtask

  task automatic wait_mem(logic v);
    int n = 0;
    while (mem_req !== v && n < 100) begin
      tick;
      n++;
    end
    check("mem_req_wait", {31'b0, mem_req}, {31'b0, v});
  endtask

  task automatic drain;
    int n = 0;
    while ((exp_addr.size() != 0 || exp_word.size() != 0) && n < 300) begin
      tick;
      n++;
    end
    check("drain", 32'(exp_addr.size() + exp_word.size()), 0);
    tick;
    tick;
  endtask

  task automatic single(bit dc, logic [31:0] a);
    push_burst(dc, a);
    if (dc) begin dc_addr = a; dc_req = 1'b1; end
    else begin ic_addr = a; ic_req = 1'b1; end
    wait_mem(1'b1);
    tick;
    if (dc) dc_req = 1'b0;
    else ic_req = 1'b0;
    drain;
  endtask

  task automatic req_both(logic [31:0] ia, logic [31:0] da, bit dc_first);
    if (dc_first) begin push_burst(1, da); push_burst(0, ia); end
    else begin push_burst(0, ia); push_burst(1, da); end
    ic_addr = ia;
    dc_addr = da;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    wait_mem(1'b1);
    tick;
    if (dc_first) dc_req = 1'b0;
    else ic_req = 1'b0;
    wait_mem(1'b0);
    wait_mem(1'b1);
    tick;
    ic_req = 1'b0;
    dc_req = 1'b0;
    drain;
  endtask

  initial begin
    int c0, base, n;
    #3;
    check("rst_req", {31'b0, mem_req}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_flags", {24'b0, ic_wvalid, ic_done, dc_wvalid, dc_done, ic_widx, dc_widx}, 0);
    tick;
    tick;
    reset = 1'b0;
    tick;
    // tie straight out of reset: icache wins first
    req_both(32'h0000_0100, 32'h0000_8000, 1'b0);
    // single icache miss with latency checks
    push_burst(0, 32'h0000_1234);
    ic_addr = 32'h0000_1234;
    ic_req  = 1'b1;
    c0      = cyc;
    #1 check("idle_no_req", {31'b0, mem_req}, 0);
    tick;
    check("req_latency", {31'b0, mem_req}, 1);
    ic_req = 1'b0;
    drain;
    check("done_latency", last_done_cyc, c0 + 5);
    // tie after an icache grant: dcache wins first
    req_both(32'h0000_0300, 32'h0000_9004, 1'b1);
    // wait states
    ack_mode = 1'b1;
    single(0, 32'h0000_4440);
    ack_mode = 1'b0;
    tick;
    // dcache miss, requester drops after first ack
    single(1, 32'h0000_2008);
    // mid-burst reset
    push_burst(0, 32'h0000_0700);
    ic_addr = 32'h0000_0700;
    ic_req  = 1'b1;
    base    = acks_seen;
    n       = 0;
    while (acks_seen - base < 2 && n < 100) begin
      tick;
      n++;
    end
    reset  = 1'b1;
    ic_req = 1'b0;
    #1;
    check("abort_req", {31'b0, mem_req}, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_done", {30'b0, ic_done, dc_done}, 0);
    check("abort_words_left", 32'(exp_word.size()), 3);
    exp_addr.delete();
    exp_word.delete();
    tick;
    tick;
    check("rst_hold_req", {31'b0, mem_req}, 0);
    reset = 1'b0;
    tick;
    req_both(32'h0000_0500, 32'h0000_0600, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
